test_tree_add: RTL and testbench
================================

// Module: test_tree_add
// PURPOSE
// - Pipelined sum of four IEEE-754 binary32 operands through a 2-level adder tree:
//   (A0+A1) + (A2+A3).
// - Top-level floating-point reduction test block.
// - Inputs are sampled when start=1; the sum appears on Result after a fixed latency.
// PARAMETERS
// - N_IN   4   operand count; fixed (tree depth 2), not overridable.
// - ADD_LAT 3  pipeline stages per fp32 adder (align, add, normalize/round).
// PORTS
// - clk        in   1        single clock, rising edge.
// - rst        in   1        synchronous, active-high reset.
// - start      in   1        input-valid qualifier; Array is sampled on every clk edge where start=1.
// - Array[3:0] in   4x32     unpacked array of binary32 operands.
// - Result     out  32       binary32 sum, registered.
// - done       out  1        1-cycle pulse when Result carries a new sum.
// BEHAVIOUR
// - Reset: all pipeline registers, Result=32'h0 and done=0 when rst=1 at a clk edge.
// - Reset mid-operation discards all in-flight sums; there is no pending output after reset.
// - Fully pipelined: one new operand set is accepted per cycle; start may stay high continuously.
// - Latency: 2*ADD_LAT = 6 cycles from the sampling edge to the edge that updates Result.
//   done is high for that one cycle per accepted set.
// - Result holds its last value while no new sum arrives; start=0 never clears Result.
// - The start=1 valid bit travels alongside data through the pipeline.
//   Result and done update only for valid slots.
// - Adder rules (each of the 3 instances):
//   * Stage 1 align: swap so |a|>=|b|; right-shift the smaller significand by the exponent
//     difference, keeping guard, round and sticky bits; shift >=27 collapses to sticky.
//   * Stage 2 add: add significands when signs are equal, otherwise subtract (25-bit+GRS).
//   * Stage 3 normalize: handle 1-bit carry-out right shift or leading-zero left shift.
//     Round to nearest, ties to even; handle re-normalization on rounding overflow.
// - Special cases:
//   * Subnormal inputs are flushed to +/-0, and subnormal results are flushed to +0.
//   * Exact cancellation gives +0.
//   * Exponent overflow gives +/-Inf.
//   * Any NaN input, or Inf + (-Inf), gives canonical qNaN 32'h7FC00000.
//   * Inf plus a finite value gives that Inf.
// - Summation order is fixed (pairwise as above); results are bit-exact to that order with
//   RNE at every node.
// STRUCTURE
// - Package fp32_pkg holds:
//   * typedef struct packed {logic s; logic [7:0] e; logic [22:0] f;} fp32_t
//   * constants FP32_QNAN, FP32_PINF, BIAS=127.
// - Sub-module fp32_add (clk, rst, in_valid, a, b, out_valid, y), ADD_LAT=3 stages.
//   Instantiated twice at level 1 and once at level 2.
// - Top level: input mux, valid propagation, and the Result/done output registers only.
// TESTING
// - 1.2,1.4,1.8,1.9 (3F99999A,3FB33333,3FE66666,3FF33333), start=1 -> Result=40C99999
//   (6.3) after 6 cycles, done pulses once.
// - 1.0 x4 (3F800000) -> 40800000; then 1.0,-1.0,2.0,-2.0 on the next cycle -> 00000000
//   one cycle later (back-to-back throughput).
// - 3F800000,7F800000,3F800000,3F800000 -> 7F800000.
//   7F800000,FF800000,0,0 -> 7FC00000.
// - 7F7FFFFF x4 -> 7F800000 (overflow).
//   3F800000,33800000,0,0 -> 3F800000 (tie to even).
// - Stream 4 sets, assert rst on cycle 3 -> no done pulse afterwards, Result=0 until the
//   next start.
// - Random 10k operand sets vs a reference model (pairwise binary32 RNE, FTZ) -> bit-exact
//   match on every done pulse.

Source files
------------

// File: rtl/fp32_pkg.sv
// Shared binary32 definitions for the adder tree.
// Contents:
//   fp32_t     - packed sign/exponent/fraction view of a binary32 word
//   FP32_QNAN  - canonical quiet NaN produced by every invalid operation
//   FP32_PINF  - +Inf encoding (OR in the sign bit for -Inf)
//   BIAS       - binary32 exponent bias
//   N_IN       - operand count of the reduction tree (fixed, depth 2)
//   ADD_LAT    - register stages inside one fp32_add
//   lzc27()    - leading-zero count of a 27-bit significand+GRS field
package fp32_pkg;

    typedef struct packed {
        logic        s;
        logic [7:0]  e;
        logic [22:0] f;
    } fp32_t;

    localparam logic [31:0] FP32_QNAN = 32'h7FC0_0000;
    localparam logic [31:0] FP32_PINF = 32'h7F80_0000;
    localparam int unsigned BIAS      = 127;
    localparam int unsigned N_IN      = 4;
    localparam int unsigned ADD_LAT   = 3;

    // Returns 27 for an all-zero input; callers treat a zero sum separately.
    function automatic logic [4:0] lzc27(input logic [26:0] v);
        logic [4:0] n;
        n = 5'd27;
        for (int i = 0; i < 27; i++) begin
            if (v[i]) n = 5'(26 - i);
        end
        return n;
    endfunction

endpackage

// File: rtl/test_tree_add_if.sv
// Operand/result bundle of the four-input binary32 adder tree.
// Signals:
//   start   - operand set valid; Array is sampled on every edge where it is high
//   Array   - N_IN binary32 operands
//   Result  - registered binary32 sum
//   done    - one-cycle pulse when Result carries a new sum
// Modports: master drives operands (bench side), slave is the tree itself.
interface test_tree_add_if;
    import fp32_pkg::*;

    logic        start;
    logic [31:0] Array [N_IN];
    logic [31:0] Result;
    logic        done;

    modport master (output start, output Array, input Result, input done);
    modport slave  (input start, input Array, output Result, output done);

endinterface

// File: rtl/fp32_add.sv
// Three-stage pipelined binary32 adder (align, add, normalize/round), RNE, FTZ.
// Ports:
//   clk, rst   - clock, synchronous active-high reset
//   in_valid   - a/b carry a valid operand pair this cycle
//   a, b       - binary32 operands
//   out_valid  - y carries the sum of the pair accepted three edges earlier
//   y          - binary32 sum (subnormal/zero results as +0, overflow to Inf, canonical qNaN)
module fp32_add
    import fp32_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        out_valid,
    output logic [31:0] y
);

    // ---------------- Stage 1: classify, order by magnitude, align ----------------
    fp32_t       w_a, w_b, w_big, w_sml;
    logic        w_a_nan, w_b_nan, w_a_inf, w_b_inf;
    logic [30:0] w_a_mag, w_b_mag;
    logic        w_swap;
    logic [23:0] w_big_sig, w_sml_sig;
    logic [7:0]  w_shift;
    logic [53:0] w_ext;
    logic [26:0] w_sml_al;

    assign w_a = a;
    assign w_b = b;
    assign w_a_nan = (w_a.e == 8'hFF) && (w_a.f != 23'd0);
    assign w_b_nan = (w_b.e == 8'hFF) && (w_b.f != 23'd0);
    assign w_a_inf = (w_a.e == 8'hFF) && (w_a.f == 23'd0);
    assign w_b_inf = (w_b.e == 8'hFF) && (w_b.f == 23'd0);

    // Subnormals rank as zero so the flushed operand always ends up as the smaller one.
    assign w_a_mag = (w_a.e == 8'd0) ? 31'd0 : {w_a.e, w_a.f};
    assign w_b_mag = (w_b.e == 8'd0) ? 31'd0 : {w_b.e, w_b.f};
    assign w_swap  = w_b_mag > w_a_mag;
    assign w_big   = w_swap ? w_b : w_a;
    assign w_sml   = w_swap ? w_a : w_b;

    assign w_big_sig = (w_big.e == 8'd0) ? 24'd0 : {1'b1, w_big.f};
    assign w_sml_sig = (w_sml.e == 8'd0) ? 24'd0 : {1'b1, w_sml.f};
    assign w_shift   = w_big.e - w_sml.e;

    // Upper 27 bits are sig+GRS after the shift, lower 27 bits catch what falls off.
    assign w_ext = {w_sml_sig, 30'd0} >> w_shift;

    always_comb begin
        w_sml_al = {w_ext[53:28], w_ext[27] | (|w_ext[26:0])};
        if (w_shift >= 8'd27) begin
            w_sml_al = {26'd0, |w_sml_sig};
        end
    end

    logic        r1_valid, r1_sign, r1_sub, r1_nan, r1_inf, r1_inf_s;
    logic [7:0]  r1_exp;
    logic [26:0] r1_big, r1_sml;

    always_ff @(posedge clk) begin
        if (rst) begin
            r1_valid <= 1'b0;
            r1_sign  <= 1'b0;
            r1_sub   <= 1'b0;
            r1_nan   <= 1'b0;
            r1_inf   <= 1'b0;
            r1_inf_s <= 1'b0;
            r1_exp   <= 8'd0;
            r1_big   <= 27'd0;
            r1_sml   <= 27'd0;
        end else begin
            r1_valid <= in_valid;
            r1_sign  <= w_big.s;
            r1_sub   <= w_big.s ^ w_sml.s;
            r1_nan   <= w_a_nan | w_b_nan | (w_a_inf & w_b_inf & (w_a.s ^ w_b.s));
            r1_inf   <= w_a_inf | w_b_inf;
            r1_inf_s <= w_a_inf ? w_a.s : w_b.s;
            r1_exp   <= w_big.e;
            r1_big   <= {w_big_sig, 3'b000};
            r1_sml   <= w_sml_al;
        end
    end

    // ---------------- Stage 2: significand add/subtract ----------------
    // |big| >= |small|, so the difference never goes negative.
    logic [27:0] w_sum;

    assign w_sum = r1_sub ? ({1'b0, r1_big} - {1'b0, r1_sml})
                          : ({1'b0, r1_big} + {1'b0, r1_sml});

    logic        r2_valid, r2_sign, r2_nan, r2_inf, r2_inf_s;
    logic [7:0]  r2_exp;
    logic [27:0] r2_sum;

    always_ff @(posedge clk) begin
        if (rst) begin
            r2_valid <= 1'b0;
            r2_sign  <= 1'b0;
            r2_nan   <= 1'b0;
            r2_inf   <= 1'b0;
            r2_inf_s <= 1'b0;
            r2_exp   <= 8'd0;
            r2_sum   <= 28'd0;
        end else begin
            r2_valid <= r1_valid;
            r2_sign  <= r1_sign;
            r2_nan   <= r1_nan;
            r2_inf   <= r1_inf;
            r2_inf_s <= r1_inf_s;
            r2_exp   <= r1_exp;
            r2_sum   <= w_sum;
        end
    end

    // ---------------- Stage 3: normalize, round, special cases ----------------
    logic [4:0]        w_lz;
    logic [26:0]       w_norm;
    logic signed [9:0] w_exp_n, w_exp_f;
    logic              w_up;
    logic [24:0]       w_rnd;
    logic [22:0]       w_mant;
    logic [31:0]       w_y;

    assign w_lz = lzc27(r2_sum[26:0]);

    always_comb begin
        if (r2_sum[27]) begin
            w_norm  = {r2_sum[27:2], r2_sum[1] | r2_sum[0]};
            w_exp_n = $signed({2'b00, r2_exp}) + 10'sd1;
        end else begin
            // Shifts of more than one place only happen when no bits were lost in alignment.
            w_norm  = r2_sum[26:0] << w_lz;
            w_exp_n = $signed({2'b00, r2_exp}) - $signed({5'd0, w_lz});
        end

        w_up    = w_norm[2] & (w_norm[1] | w_norm[0] | w_norm[3]);
        w_rnd   = {1'b0, w_norm[26:3]} + {24'd0, w_up};
        w_mant  = w_rnd[24] ? w_rnd[23:1] : w_rnd[22:0];
        w_exp_f = w_exp_n + (w_rnd[24] ? 10'sd1 : 10'sd0);

        w_y = {r2_sign, w_exp_f[7:0], w_mant};
        if (r2_sum == 28'd0) begin
            w_y = 32'h0;
        end else if (w_exp_f >= 10'sd255) begin
            w_y = FP32_PINF | {r2_sign, 31'd0};
        end else if (w_exp_f <= 10'sd0) begin
            w_y = 32'h0;
        end
        if (r2_inf) w_y = FP32_PINF | {r2_inf_s, 31'd0};
        if (r2_nan) w_y = FP32_QNAN;
    end

    logic        r3_valid;
    logic [31:0] r3_y;

    always_ff @(posedge clk) begin
        if (rst) begin
            r3_valid <= 1'b0;
            r3_y     <= 32'h0;
        end else begin
            r3_valid <= r2_valid;
            if (r2_valid) r3_y <= w_y;
        end
    end

    assign out_valid = r3_valid;
    assign y         = r3_y;

endmodule

// File: rtl/test_tree_add.sv
// Four-input binary32 reduction (A0+A1)+(A2+A3) built from three pipelined fp32_add
// instances; one operand set per cycle, six edges from sampling to Result.
// Ports:
//   clk  - clock, rising edge
//   rst  - synchronous active-high reset; drops every in-flight sum
//   bus  - slave side of test_tree_add_if (start/Array in, Result/done out)
module test_tree_add
    import fp32_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    test_tree_add_if.slave        bus
);

    logic        w_v01, w_v23, w_vr;
    logic [31:0] w_s01, w_s23, w_sr;

    fp32_add u_add_01 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (bus.start),
        .a         (bus.Array[0]),
        .b         (bus.Array[1]),
        .out_valid (w_v01),
        .y         (w_s01)
    );

    fp32_add u_add_23 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (bus.start),
        .a         (bus.Array[2]),
        .b         (bus.Array[3]),
        .out_valid (w_v23),
        .y         (w_s23)
    );

    fp32_add u_add_root (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (w_v01 & w_v23),
        .a         (w_s01),
        .b         (w_s23),
        .out_valid (w_vr),
        .y         (w_sr)
    );

    logic [31:0] r_result;
    logic        r_done;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_result <= 32'h0;
            r_done   <= 1'b0;
        end else begin
            r_done <= w_vr;
            if (w_vr) r_result <= w_sr;
        end
    end

    assign bus.Result = r_result;
    assign bus.done   = r_done;

endmodule

// File: tb/tb_test_tree_add.sv
// Bench for test_tree_add: directed cases followed by 10k random operand sets, each
// expected sum computed by a real-arithmetic binary32 reference and matched on its
// due cycle; done and Result are checked on every cycle.
module tb_test_tree_add;
    import fp32_pkg::*;

    logic clk;
    logic rst;

    test_tree_add_if bus ();

    test_tree_add dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int          n_total = 0;
    int          n_pass  = 0;
    int          n_fail  = 0;
    int          cyc     = 0;
    logic [31:0] q_exp [$];
    int          q_due [$];
    logic [31:0] last_exp = 32'h0;

    // ---------------- reference model ----------------
    function automatic real fp_to_real(input logic [31:0] x);
        logic [63:0] d;
        if (x[30:23] == 8'd0) return 0.0;
        d = {x[31], 11'(int'(x[30:23]) + 1023 - int'(BIAS)), x[22:0], 29'd0};
        return $bitstoreal(d);
    endfunction

    // Round a double to binary32 (RNE); tiny results and zeros become +0.
    function automatic logic [31:0] real_to_fp(input real r);
        logic [63:0] d;
        logic [52:0] sig;
        logic [24:0] m;
        logic        up;
        int          e;
        d = $realtobits(r);
        if (d[62:0] == 63'd0) return 32'h0;
        sig = {1'b1, d[51:0]};
        up  = sig[28] & ((|sig[27:0]) | sig[29]);
        m   = {1'b0, sig[52:29]} + {24'd0, up};
        e   = int'(d[62:52]) - 1023 + int'(BIAS);
        if (m[24]) begin
            m = m >> 1;
            e++;
        end
        if (e >= 255) return FP32_PINF | {d[63], 31'd0};
        if (e <= 0) return 32'h0;
        return {d[63], e[7:0], m[22:0]};
    endfunction

    function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b);
        logic a_nan, b_nan, a_inf, b_inf;
        a_nan = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
        b_nan = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
        a_inf = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
        b_inf = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);
        if (a_nan || b_nan) return FP32_QNAN;
        if (a_inf && b_inf && (a[31] != b[31])) return FP32_QNAN;
        if (a_inf) return a;
        if (b_inf) return b;
        // Double precision is wide enough that rounding twice equals one binary32 rounding.
        return real_to_fp(fp_to_real(a) + fp_to_real(b));
    endfunction

    function automatic logic [31:0] ref_sum(input logic [31:0] a0, input logic [31:0] a1,
                                            input logic [31:0] a2, input logic [31:0] a3);
        return fp_add(fp_add(a0, a1), fp_add(a2, a3));
    endfunction

    function automatic logic [31:0] rand_fp();
        logic [31:0] sp [10];
        logic [31:0] v;
        int unsigned k;
        sp = '{32'h0000_0000, 32'h8000_0000, 32'h7F80_0000, 32'hFF80_0000, 32'h7FC0_0000,
               32'hFF80_0001, 32'h0000_0123, 32'h7F7F_FFFF, 32'h0080_0000, 32'h8080_0000};
        v = $urandom;
        k = $urandom_range(0, 15);
        if (k == 0) return v;
        if (k == 1) return sp[$urandom_range(0, 9)];
        if (k == 2) return {v[31], 8'(250 + $urandom_range(0, 4)), v[22:0]};
        if (k == 3) return {v[31], 8'(1 + $urandom_range(0, 3)), v[22:0]};
        return {v[31], 8'(124 + $urandom_range(0, 6)), v[22:0]};
    endfunction

    // ---------------- checking ----------------
    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h at cycle %0d", tag, obs, exp, cyc);
        end
    endtask

    // Drive one cycle, then check done/Result against the scoreboard.
    task automatic step(input logic st, input logic rs,
                        input logic [31:0] a0, input logic [31:0] a1,
                        input logic [31:0] a2, input logic [31:0] a3,
                        input logic [31:0] exp_sum);
        logic exp_done;
        bus.start    = st;
        bus.Array[0] = a0;
        bus.Array[1] = a1;
        bus.Array[2] = a2;
        bus.Array[3] = a3;
        rst          = rs;
        @(posedge clk);
        #1;
        cyc++;
        if (rs) begin
            q_exp.delete();
            q_due.delete();
            last_exp = 32'h0;
        end
        exp_done = 1'b0;
        if (q_due.size() != 0) exp_done = (q_due[0] == cyc);
        check32("done", {31'd0, bus.done}, {31'd0, exp_done});
        if (exp_done) begin
            last_exp = q_exp.pop_front();
            void'(q_due.pop_front());
        end
        check32("result", bus.Result, last_exp);
        if (st && !rs) begin
            q_exp.push_back(exp_sum);
            q_due.push_back(cyc + 2 * int'(ADD_LAT));
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            step(1'b0, 1'b0, $urandom, $urandom, $urandom, $urandom, 32'h0);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] r0, r1, r2, r3;
        rst       = 1'b1;
        bus.start = 1'b0;
        for (int i = 0; i < int'(N_IN); i++) bus.Array[i] = 32'h0;

        // Reset state
        step(1'b0, 1'b1, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0);
        step(1'b0, 1'b1, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0);
        idle(2);

        // 1.2 + 1.4 + 1.8 + 1.9 -> 6.3
        step(1'b1, 1'b0, 32'h3F99999A, 32'h3FB33333, 32'h3FE66666, 32'h3FF33333, 32'h40C99999);
        idle(8);

        // Back-to-back sets
        step(1'b1, 1'b0, 32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h40800000);
        step(1'b1, 1'b0, 32'h3F800000, 32'hBF800000, 32'h40000000, 32'hC0000000, 32'h00000000);
        idle(8);

        // Infinity handling
        step(1'b1, 1'b0, 32'h3F800000, 32'h7F800000, 32'h3F800000, 32'h3F800000, 32'h7F800000);
        step(1'b1, 1'b0, 32'h7F800000, 32'hFF800000, 32'h00000000, 32'h00000000, 32'h7FC00000);
        idle(8);

        // Overflow, tie to even
        step(1'b1, 1'b0, 32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F800000);
        step(1'b1, 1'b0, 32'h3F800000, 32'h33800000, 32'h00000000, 32'h00000000, 32'h3F800000);
        idle(8);

        // Reset while four sets are in flight
        step(1'b1, 1'b0, 32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h40800000);
        step(1'b1, 1'b0, 32'h40000000, 32'h40000000, 32'h40000000, 32'h40000000, 32'h41000000);
        step(1'b1, 1'b0, 32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000, 32'h41200000);
        step(1'b1, 1'b1, 32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h40800000);
        idle(10);
        step(1'b1, 1'b0, 32'h40000000, 32'h3F800000, 32'h3F800000, 32'h00000000, 32'h40800000);
        idle(8);

        // Random operand sets with occasional bubbles and near-cancelling pairs
        for (int n = 0; n < 10000; n++) begin
            r0 = rand_fp();
            r1 = rand_fp();
            r2 = rand_fp();
            r3 = rand_fp();
            if ($urandom_range(0, 7) == 0) r1 = {~r0[31], r0[30:2], r0[1:0] ^ 2'($urandom_range(0, 3))};
            if ($urandom_range(0, 7) == 0) r3 = {~r2[31], r2[30:2], r2[1:0] ^ 2'($urandom_range(0, 3))};
            if ($urandom_range(0, 7) == 0) idle(1);
            step(1'b1, 1'b0, r0, r1, r2, r3, ref_sum(r0, r1, r2, r3));
        end
        idle(10);
        check32("drain", 32'(q_exp.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
